// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the I/D memory port arbiter.
//   rsp_owner_e : which requester owns the read data returning this cycle
//   DEF_ADDR_W / DEF_DATA_W : default bus widths
//   starve_w()  : width of a counter that must hold values 0..limit
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    RSP_NONE   = 2'd0,
    RSP_IFETCH = 2'd1,
    RSP_DLOAD  = 2'd2
  } rsp_owner_e;

  function automatic int starve_w(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter tracking consecutive denied fetch cycles.
// Ports:
//   clk, reset (sync, active-low)
//   inc      : count one more denied cycle (ignored once at LIMIT)
//   clr      : return to zero; wins over inc
//   at_limit : counter has reached LIMIT
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int W = starve_w(LIMIT);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIM)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch port (I,
// read-only) and the load/store port (D). D has fixed priority; after
// STARVE_LIMIT consecutive denied fetch cycles, I wins the next conflict.
// Read data returns one cycle after the grant, routed to the requester that
// won; the other port's rdata reads as 0.
// Optional build macro MEM_PORT_ARBITER_PERF_EN adds conflict_cnt and
// forced_i_cnt performance counters.
// Ports:
//   clk, reset (sync, active-low)
//   i_req/i_addr -> i_gnt, i_rvalid, i_rdata        fetch side
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid, d_rdata   load/store side
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata      memory side
//
// Response FSM (rsp_owner):
//   state      | meaning
//   RSP_NONE   | no read data returning this cycle
//   RSP_IFETCH | mem_rdata belongs to the fetch port
//   RSP_DLOAD  | mem_rdata belongs to the load/store port
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
`ifdef MEM_PORT_ARBITER_PERF_EN
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       forced_i_cnt,
`endif
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  rsp_owner_e rsp_owner;
  logic       at_limit;
  logic       i_win;
  logic       d_win;

  // Everything is gated by reset so the memory sees no access while held.
  assign i_win = reset & i_req & (~d_req | at_limit);
  assign d_win = reset & d_req & ~(i_req & at_limit);

  assign i_gnt     = i_win;
  assign d_gnt     = d_win;
  assign mem_en    = i_win | d_win;
  assign mem_we    = d_win & d_we;
  assign mem_addr  = d_win ? d_addr : (i_win ? i_addr : '0);
  assign mem_wdata = d_win ? d_wdata : '0;

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (i_req & ~i_win),
    .clr      (i_win | ~i_req),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_owner <= RSP_NONE;
    end else if (i_win) begin
      rsp_owner <= RSP_IFETCH;
    end else if (d_win && !d_we) begin
      rsp_owner <= RSP_DLOAD;
    end else begin
      rsp_owner <= RSP_NONE;
    end
  end

  // Gating with reset drops a response that was in flight when reset hit.
  assign i_rvalid = reset & (rsp_owner == RSP_IFETCH);
  assign d_rvalid = reset & (rsp_owner == RSP_DLOAD);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

`ifdef MEM_PORT_ARBITER_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      conflict_cnt <= '0;
      forced_i_cnt <= '0;
    end else if (i_req && d_req) begin
      conflict_cnt <= conflict_cnt + 32'd1;
      if (i_win) begin
        forced_i_cnt <= forced_i_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] conflict_cnt;
  logic [31:0] forced_i_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
`ifdef MEM_PORT_ARBITER_PERF_EN
    .conflict_cnt (conflict_cnt),
    .forced_i_cnt (forced_i_cnt),
`endif
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port synchronous memory, preloaded on the first edge.
  logic [31:0] mem [0:255];
  logic        preload_done = 1'b0;
  always @(posedge clk) begin
    if (!preload_done) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
      mem[8'h04] <= 32'h00500093;  // 0x10
      mem[8'h08] <= 32'h11111111;  // 0x20
      mem[8'h11] <= 32'h22222222;  // 0x44
      mem[8'h20] <= 32'h33333333;  // 0x80
      preload_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        ig;
    logic        dg;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } gnt_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rsp_exp_t;

  gnt_exp_t gq[$];
  rsp_exp_t iq[$];
  rsp_exp_t dq[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every driven cycle has a grant record; responses are checked
  // against the per-port queues, and an absent entry means rvalid=0, rdata=0.
  gnt_exp_t me;
  rsp_exp_t mr;
  always @(negedge clk) begin
    if (gq.size() > 0 && gq[0].cyc == cyc) begin
      me = gq.pop_front();
      chk("i_gnt",     {31'd0, i_gnt},  {31'd0, me.ig});
      chk("d_gnt",     {31'd0, d_gnt},  {31'd0, me.dg});
      chk("mem_en",    {31'd0, mem_en}, {31'd0, me.en});
      chk("mem_we",    {31'd0, mem_we}, {31'd0, me.we});
      chk("mem_addr",  mem_addr,  me.addr);
      chk("mem_wdata", mem_wdata, me.wd);
      if (iq.size() > 0 && iq[0].cyc == cyc) begin
        mr = iq.pop_front();
        chk("i_rvalid", {31'd0, i_rvalid}, 32'd1);
        chk("i_rdata",  i_rdata, mr.data);
      end else begin
        chk("i_rvalid", {31'd0, i_rvalid}, 32'd0);
        chk("i_rdata",  i_rdata, 32'd0);
      end
      if (dq.size() > 0 && dq[0].cyc == cyc) begin
        mr = dq.pop_front();
        chk("d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("d_rdata",  d_rdata, mr.data);
      end else begin
        chk("d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("d_rdata",  d_rdata, 32'd0);
      end
    end
  end

  // g: 0 = no grant, 1 = I granted, 2 = D granted. rexp is the read data
  // expected on the winner's port next cycle; drop suppresses that response.
  task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dwe, input logic [31:0] da,
                      input logic [31:0] dd, input int g, input logic [31:0] rexp,
                      input bit drop);
    gnt_exp_t e;
    rsp_exp_t r;
    @(posedge clk);
    #1;
    reset = rst; i_req = ir; i_addr = ia;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dd;
    e.cyc  = cyc;
    e.ig   = (g == 1);
    e.dg   = (g == 2);
    e.en   = (g != 0);
    e.we   = (g == 2) && dwe;
    e.addr = (g == 1) ? ia : ((g == 2) ? da : 32'h0);
    e.wd   = (g == 2) ? dd : 32'h0;
    gq.push_back(e);
    r.cyc  = cyc + 1;
    r.data = rexp;
    if (!drop) begin
      if (g == 1) iq.push_back(r);
      else if (g == 2 && !dwe) dq.push_back(r);
    end
  endtask

  // Starvation pattern with STARVE_LIMIT=4: D,D,D,D,I repeating.
  int starve_pat [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

  initial begin
    reset = 1'b0; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset held with both requesting: everything stays quiet.
    repeat (3) step(0, 1, 32'h20, 1, 0, 32'h44, 32'h0, 0, 32'h0, 0);
    // Release: D wins first, then I alone.
    step(1, 1, 32'h20, 1, 0, 32'h44, 32'h0, 2, 32'h22222222, 0);
    step(1, 1, 32'h20, 0, 0, 32'h0,  32'h0, 1, 32'h11111111, 0);
    // Fetch only.
    step(1, 1, 32'h10, 0, 0, 32'h0,  32'h0, 1, 32'h00500093, 0);
    // Store then load the same address.
    step(1, 0, 32'h0,  1, 1, 32'h40, 32'hDEADBEEF, 2, 32'h0, 0);
    step(1, 0, 32'h0,  1, 0, 32'h40, 32'h0, 2, 32'hDEADBEEF, 0);
    step(1, 0, 32'h0,  0, 0, 32'h0,  32'h0, 0, 32'h0, 0);
    // Build up starvation, then reset with a load response in flight.
    step(1, 1, 32'h10, 1, 0, 32'h80, 32'h0, 2, 32'h33333333, 0);
    step(1, 1, 32'h10, 1, 0, 32'h80, 32'h0, 2, 32'h33333333, 1);
    step(0, 1, 32'h10, 1, 0, 32'h80, 32'h0, 0, 32'h0, 0);
    // Continuous conflict from a freshly cleared starvation count.
    for (int k = 0; k < 10; k++) begin
      step(1, 1, 32'h10, 1, 0, 32'h80, 32'h0, starve_pat[k],
           (starve_pat[k] == 1) ? 32'h00500093 : 32'h33333333, 0);
    end
    // Single-request alternation I, D, I.
    step(1, 1, 32'h10, 0, 0, 32'h0,  32'h0, 1, 32'h00500093, 0);
    step(1, 0, 32'h0,  1, 0, 32'h40, 32'h0, 2, 32'hDEADBEEF, 0);
    step(1, 1, 32'h20, 0, 0, 32'h0,  32'h0, 1, 32'h11111111, 0);
    step(1, 0, 32'h0,  0, 0, 32'h0,  32'h0, 0, 32'h0, 0);
    step(1, 0, 32'h0,  0, 0, 32'h0,  32'h0, 0, 32'h0, 0);

    @(posedge clk);
    @(negedge clk);
`ifdef MEM_PORT_ARBITER_PERF_EN
    chk("conflict_cnt", conflict_cnt, 32'd10);
    chk("forced_i_cnt", forced_i_cnt, 32'd2);
`endif
    chk("queues_drained", gq.size() + iq.size() + dq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous data/instruction memory between the pipeline's fetch port (I, read-only) and load/store port (D, read/write).
- Sits between riscvpipeline and a unified mem instance.
- Grants one access per cycle, with fixed D priority and a starvation bound for I.
- Returns read data one cycle after grant, tagged to the winning requester.

Parameters:
- ADDR_W, 32, address width for both ports and the memory.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive denied I cycles after which I wins a conflict; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr until i_gnt.
- i_addr  in  ADDR_W  fetch address.
- i_gnt  out  1  fetch granted this cycle.
- i_rvalid  out  1  i_rdata valid (cycle after i_gnt).
- i_rdata  out  DATA_W  fetch data.
- d_req  in  1  load/store request; held with d_addr, d_we and d_wdata until d_gnt.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data access granted this cycle.
- d_rvalid  out  1  d_rdata valid (cycle after a granted load).
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read with mem_en=1 and mem_we=0.

Behaviour:
- **Grant logic:** combinational from requests and state; grants are one-hot or zero.
  - Only d_req: d_gnt=1.
  - Only i_req: i_gnt=1.
  - Both requesting: d_gnt=1, unless starve_cnt == STARVE_LIMIT, in which case i_gnt=1.
- **Memory drive:** mem_en = i_gnt | d_gnt. mem_we = d_gnt & d_we. mem_addr and mem_wdata are muxed from the winner. When idle, mem_addr and mem_wdata are 0.
- **starve_cnt:**
  - Increments when i_req=1 and i_gnt=0.
  - Clears to 0 on i_gnt or when i_req=0.
  - Saturates at STARVE_LIMIT.
- **Response state machine (rsp_owner register):** states NONE, IFETCH, DLOAD.
  - Next state is IFETCH if i_gnt; DLOAD if d_gnt & ~d_we; otherwise NONE. Stores always yield NONE.
  - In IFETCH: i_rvalid=1 and i_rdata=mem_rdata.
  - In DLOAD: d_rvalid=1 and d_rdata=mem_rdata.
  - The non-owner rdata output is 0. A new grant may occur in the same cycle a response is returned, giving full throughput of 1 access per cycle.
- **Latency:** grant in cycle N gives rvalid in cycle N+1. Stores complete at the clk edge ending the grant cycle. A load to the same address granted in N+1 sees the stored data.
- **Reset (reset=0 at a clk edge):**
  - rsp_owner=NONE and starve_cnt=0.
  - While reset=0, all grants, mem_en, mem_we, rvalids, rdata, mem_addr and mem_wdata are forced to 0.
  - A response pending at reset is dropped and never delivered.
- **Boundary cases:**
  - Request deasserted without a grant is a protocol violation. The arbiter does not remember it.
  - STARVE_LIMIT=1: under continuous conflict, grants alternate D, I, D, I.
  - Address wrap-around is not handled here; it is the memory's concern.

Optional Feature:
- Macro: MEM_PORT_ARBITER_PERF_EN.
- **When defined:** adds output ports conflict_cnt (32) and forced_i_cnt (32).
  - conflict_cnt increments each cycle with i_req & d_req.
  - forced_i_cnt increments each conflict cycle won by I.
  - Both wrap modulo 2^32 and clear on reset.
- **When undefined:** ports and counters are absent; function is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - enum rsp_owner_e {RSP_NONE, RSP_IFETCH, RSP_DLOAD};
  - localparams for default ADDR_W and DATA_W;
  - function starve_w(limit) returning the counter width.
- One sub-module, arb_starve_counter: saturating counter with inc/clr/at_limit, parameterised by LIMIT.

Test Plan:
1. Reset: hold reset=0 3 cycles with i_req=d_req=1 -> all outputs 0. Release -> d_gnt=1 first cycle, mem_addr=d_addr.
2. Fetch only: i_req=1, i_addr=0x10, memory holds 0x00500093 at 0x10 -> i_gnt=1 in cycle N; i_rvalid=1, i_rdata=0x00500093 in N+1.
3. Store then load: d store 0xDEADBEEF to 0x40, then load 0x40 the next cycle -> mem_we=1 in the store cycle only; d_rvalid=1 with 0xDEADBEEF one cycle after the load grant; no rvalid for the store.
4. Starvation, STARVE_LIMIT=4, both requests held continuously -> grant pattern D,D,D,D,I repeating; I never waits >4 cycles; forced_i_cnt=1 after 5 cycles (PERF_EN).
5. Reset mid-operation: load granted, reset=0 on the next edge -> d_rvalid stays 0; after release starve_cnt=0 and arbitration restarts cleanly.
6. Back-to-back alternation: i then d then i, single requests -> rvalid routed to the correct port each cycle; non-owner rdata=0.
